// File: rtl/ringbuf_evt_ctrl.sv
// ringbuf_evt_ctrl: event-framed circular sample buffer with a pull readout.
// Ports: CLK, RST (async high); WREN/DIN write side; RD_EN pull,
//   DOUT/DOUT_VLD/EVT_LAST read data; EVT_AVAIL/EVT_CNT/FULL/OVFL_CNT
//   status; PERR sticky parity error.
// Optional macro RINGBUF_PARITY_EN adds a stored even-parity bit and PERR.
module ringbuf_evt_ctrl #(
    parameter int AW        = 11,
    parameter int EVT_WORDS = 128,
    parameter int EVT_CW    = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              WREN,
    input  logic [11:0]       DIN,
    input  logic              RD_EN,
    output logic [11:0]       DOUT,
    output logic              DOUT_VLD,
    output logic              EVT_LAST,
    output logic              EVT_AVAIL,
    output logic [EVT_CW-1:0] EVT_CNT,
    output logic              FULL,
    output logic [15:0]       OVFL_CNT,
    output logic              PERR
);

`ifdef RINGBUF_PARITY_EN
    localparam int DW = 13;
`else
    localparam int DW = 12;
`endif
    localparam int DEPTH = 2 ** AW;
    localparam int CW = (EVT_WORDS > 1) ? $clog2(EVT_WORDS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(EVT_WORDS - 1);

    typedef enum logic [1:0] {W_IDLE, W_STORE, W_DROP} wstate_t;
    typedef enum logic {R_IDLE, R_BURST} rstate_t;

    logic [DW-1:0]     r_mem [0:DEPTH-1];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic [CW-1:0]     r_wcnt;
    logic [CW-1:0]     r_rcnt;
    wstate_t           r_wstate;
    rstate_t           r_rstate;
    logic [DW-1:0]     r_dout;
    logic              r_dout_vld;
    logic              r_evt_last;
    logic [EVT_CW-1:0] r_evt_cnt;
    logic [15:0]       r_ovfl_cnt;

    logic [AW:0]       w_used;
    logic [AW+1:0]     w_free;
    logic              w_fits;
    logic              w_wlast;
    logic              w_rlast;
    logic              w_wr_en;
    logic              w_commit;
    logic              w_rd_acc;
    logic              w_rd_done;
    logic [DW-1:0]     w_wdata;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign w_used = r_wr_ptr - r_rd_ptr;
    assign w_free = (AW+2)'(DEPTH) - {1'b0, w_used};
    assign w_fits = w_free >= (AW+2)'(EVT_WORDS);

    // wcnt/rcnt sit at 0 in idle, so a 1-word event finishes on entry.
    assign w_wlast  = (r_wcnt == LAST_IDX);
    assign w_rlast  = (r_rcnt == LAST_IDX);
    assign w_wr_en  = WREN & (((r_wstate == W_IDLE) & w_fits) |
                              (r_wstate == W_STORE));
    assign w_commit = w_wr_en & w_wlast;
    assign w_rd_acc = RD_EN & (((r_rstate == R_IDLE) & (r_evt_cnt != '0)) |
                               (r_rstate == R_BURST));
    assign w_rd_done = w_rd_acc & w_rlast;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wstate   <= W_IDLE;
            r_wcnt     <= '0;
            r_wr_ptr   <= '0;
            r_ovfl_cnt <= '0;
        end else if (WREN) begin
            if (w_wr_en)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if ((r_wstate == W_IDLE) && !w_fits && (r_ovfl_cnt != '1))
                r_ovfl_cnt <= r_ovfl_cnt + 1'b1;
            if (w_wlast) begin
                r_wcnt   <= '0;
                r_wstate <= W_IDLE;
            end else begin
                r_wcnt <= r_wcnt + 1'b1;
                if (r_wstate == W_IDLE)
                    r_wstate <= w_fits ? W_STORE : W_DROP;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_wr_en)
            r_mem[r_wr_ptr[AW-1:0]] <= w_wdata;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rstate   <= R_IDLE;
            r_rcnt     <= '0;
            r_rd_ptr   <= '0;
            r_dout     <= '0;
            r_dout_vld <= 1'b0;
            r_evt_last <= 1'b0;
        end else begin
            r_dout_vld <= w_rd_acc;
            r_evt_last <= w_rd_done;
            if (w_rd_acc) begin
                r_dout   <= r_mem[r_rd_ptr[AW-1:0]];
                r_rd_ptr <= r_rd_ptr + 1'b1;
                if (w_rlast) begin
                    r_rcnt   <= '0;
                    r_rstate <= R_IDLE;
                end else begin
                    r_rcnt   <= r_rcnt + 1'b1;
                    r_rstate <= R_BURST;
                end
            end
        end
    end

    // Commit and read-complete together leave the count unchanged.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r_evt_cnt <= '0;
        else if (w_commit && !w_rd_done && (r_evt_cnt != '1))
            r_evt_cnt <= r_evt_cnt + 1'b1;
        else if (w_rd_done && !w_commit)
            r_evt_cnt <= r_evt_cnt - 1'b1;
    end

`ifdef RINGBUF_PARITY_EN
    logic r_perr;
    logic w_perr_now;

    assign w_wdata    = {^DIN, DIN};
    assign w_perr_now = r_dout_vld & (^r_dout);
    assign PERR       = r_perr | w_perr_now;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r_perr <= 1'b0;
        else if (w_perr_now)
            r_perr <= 1'b1;
    end
`else
    assign w_wdata = DIN;
    assign PERR    = 1'b0;
`endif

    assign DOUT      = r_dout[11:0];
    assign DOUT_VLD  = r_dout_vld;
    assign EVT_LAST  = r_evt_last;
    assign EVT_AVAIL = (r_evt_cnt != '0);
    assign EVT_CNT   = r_evt_cnt;
    assign FULL      = !w_fits;
    assign OVFL_CNT  = r_ovfl_cnt;

endmodule

// File: doc/ringbuf_evt_ctrl.md
Name: ringbuf_evt_ctrl

Overview:
- Downstream stage of the 16-channel sample transfer block.
- Consumes the WREN strobe and the 12-bit DMUX sample stream and stores samples in an inferred block-RAM circular buffer, framed into fixed-length events.
- Admits an event only if it fits whole; otherwise drops it and counts the overflow.
- Presents committed events to the readout side through a pull interface with 1-cycle read latency.

Parameters:
- AW, 11, buffer address width; depth = 2^AW words of 12 bits.
- EVT_WORDS, 128, words per event (16 channels x 8 samples); legal range 1..2^AW.
- EVT_CW, 8, width of the committed-event counter.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- WREN  in  1  sample write strobe from the transfer stage.
- DIN  in  12  sample word; valid when WREN=1.
- RD_EN  in  1  readout pull request; one word per accepted cycle.
- DOUT  out  12  read data.
- DOUT_VLD  out  1  DOUT valid; high the cycle after an accepted RD_EN.
- EVT_LAST  out  1  qualifies DOUT_VLD; marks the final word of an event.
- EVT_AVAIL  out  1  at least one committed, unread event.
- EVT_CNT  out  EVT_CW  number of committed, unread events; saturates at all-ones.
- FULL  out  1  free words < EVT_WORDS.
- OVFL_CNT  out  16  dropped events; saturates at 0xFFFF.
- PERR  out  1  sticky parity error; only meaningful with the optional feature.

Behaviour:
- Reset (async assert, sync deassert by design context):
  - Pointers, counters and outputs are 0; both FSMs return to idle.
  - FULL=0 (buffer empty).
  - RAM contents are don't-care.
- Pointers: wr_ptr and rd_ptr are AW+1 bits wide.
  - used = wr_ptr - rd_ptr (modulo 2^(AW+1)).
  - free = 2^AW - used.
  - Address = pointer[AW-1:0]; wrap-around is implicit.
- Write FSM states: W_IDLE, W_STORE, W_DROP. wcnt counts 0..EVT_WORDS-1.
  - W_IDLE + WREN:
    - If free >= EVT_WORDS: write DIN at wr_ptr, wr_ptr++, wcnt=1, go to W_STORE.
    - Else: OVFL_CNT++ (saturating), wcnt=1, go to W_DROP.
    - If EVT_WORDS=1: commit or drop completes immediately and the FSM stays in W_IDLE.
  - W_STORE + WREN: write, wr_ptr++, wcnt++. On the EVT_WORDS-th word: commit (event count +1), go to W_IDLE.
  - W_DROP + WREN: discard the word, wcnt++. On the EVT_WORDS-th word: go to W_IDLE.
  - WREN=0: hold in all states; gaps inside an event are legal.
- Read FSM states: R_IDLE, R_BURST. rcnt counts 0..EVT_WORDS-1.
  - Accept condition: RD_EN & ((R_IDLE & EVT_CNT>0) | R_BURST).
  - Accepted RD_EN: RAM read at rd_ptr, rd_ptr++, rcnt++.
  - DOUT and DOUT_VLD are registered and appear next cycle. EVT_LAST=1 with the word at rcnt=EVT_WORDS-1.
  - The last word decrements the event count and returns the FSM to R_IDLE.
  - RD_EN is ignored when not accepted; DOUT_VLD=0 on the following cycle.
- Simultaneous write-commit and read-complete in one cycle: EVT_CNT unchanged.
- Simultaneous write and read to the same address is impossible: reads touch only committed words.
- FULL is combinational from the pointers and updates the cycle after any pointer change.
- The drop decision is made only at the first word of an event. An event already in W_STORE always completes, because space was reserved at admission.

Optional Feature:
- Macro RINGBUF_PARITY_EN.
- Defined:
  - RAM is 13 bits wide; bit 12 holds even parity of DIN, computed at write.
  - On each DOUT_VLD, parity is recomputed. On mismatch PERR is set and stays set until RST.
  - DOUT still shows the stored data.
- Undefined: RAM is 12 bits wide and PERR is tied 0.

Test Plan:
- Reset then idle: outputs all 0 and FULL=0. Write 128 words 0x000..0x07F -> EVT_CNT=1, EVT_AVAIL=1. Hold RD_EN 128 cycles -> DOUT 0x000..0x07F, EVT_LAST on 0x07F, EVT_CNT=0.
- Write 16 events with no reads -> EVT_CNT=16, FULL=1. 17th event -> OVFL_CNT=1, EVT_CNT stays 16, wr_ptr unchanged.
- Read 1 event, then write 1 event -> admitted, and data crosses the address wrap 2047->0 intact.
- Commit the 2nd event in the same cycle as the read of the last word of the 1st -> EVT_CNT stays 1.
- Assert RST mid-burst after 50 words written and 30 read -> all outputs 0 immediately; the next full event is read back correctly.
- With RINGBUF_PARITY_EN: force a bit flip in a stored word -> PERR=1 on that word's DOUT_VLD and remains 1 until RST.
